pipeline_hazard_tracker: RTL and testbench
==========================================

// Module: pipeline_hazard_tracker
// PURPOSE
//  Producer side of the operand-forwarding interface. Records every register-writing
//  instruction issued from ID and advances the record through EX, MEM and WB.
//  Drives rd_mem/rd_wb/RegWrite_mem/RegWrite_wb to the forwarding unit.
//  Raises the ID stall for load-use hazards and for data-memory wait states.
//  Keeps a per-register pending-write count for debug/CSR visibility.
// PARAMETERS
//  NREG  32  number of architectural registers; x0 is never tracked
//  AW    5   register index width, = clog2(NREG)
//  CW    2   per-register pending counter width; max in flight = 3
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high; clears all state
//  id_valid      in   1      instruction in ID requests issue this cycle
//  id_rd         in   AW     destination register of the ID instruction
//  id_regwrite   in   1      ID instruction writes id_rd
//  id_is_load    in   1      ID instruction is a load; result available only after MEM
//  id_rs1        in   AW     source register 1 of the ID instruction
//  id_rs2        in   AW     source register 2 of the ID instruction
//  id_use_rs1    in   1      ID instruction reads rs1
//  id_use_rs2    in   1      ID instruction reads rs2
//  flush         in   1      squash the ID instruction (taken branch resolved in EX)
//  mem_stall     in   1      data memory not ready; freezes EX, MEM and WB
//  stall_id      out  1      combinational; hold PC and IF/ID
//  rd_ex         out  AW     EX-stage destination register
//  RegWrite_ex   out  1      EX-stage record is valid and writes rd_ex
//  rd_mem        out  AW     MEM-stage destination register, to forwarding
//  RegWrite_mem  out  1      MEM-stage record is valid and writes rd_mem
//  rd_wb         out  AW     WB-stage destination register, to forwarding
//  RegWrite_wb   out  1      WB-stage record is valid and writes rd_wb
//  pending_mask  out  NREG   bit r = 1 while cnt[r] != 0; bit 0 is always 0
// BEHAVIOUR
//  - Stage record = {valid, rd, regwrite, is_load}; one record each for EX, MEM, WB.
//  - Reset: all records invalid, all counters 0, every output 0.
//    Reset mid-operation discards all in-flight records immediately.
//  - advance = !mem_stall.
//  - lu1 = id_use_rs1 & id_rs1!=0 & EX.valid & EX.regwrite & EX.is_load & EX.rd==id_rs1.
//    lu2 is the same for rs2.
//  - stall_id = mem_stall | lu1 | lu2. stall_id must not depend on flush.
//  - accept = id_valid & !stall_id & !flush.
//  - On an edge with advance=1: WB <= MEM, MEM <= EX, EX <= accept ? ID record : bubble.
//    A bubble has valid=0.
//  - On an edge with advance=0: all three records hold and nothing is accepted.
//  - Issue event: accept & id_regwrite & id_rd!=0 -> cnt[id_rd]++ (inc).
//  - Retire event: advance & WB.valid & WB.regwrite & WB.rd!=0 -> cnt[WB.rd]-- (dec).
//  - Inc and dec on the same register in the same cycle -> count unchanged.
//  - Counter wrap (cnt=3 & inc, without dec) and underflow (cnt=0 & dec) are illegal.
//    Guard both with assertions.
//  - RegWrite_* = record.valid & record.regwrite. rd_* outputs the record rd, even when invalid.
//  - Load-use penalty is exactly 1 bubble: the load moves to MEM and lu clears.
//    The forwarding unit then supplies the operand from MEM/WB.
//  - Flush together with a load-use hazard: stall_id=1, the instruction is not accepted,
//    and the pipeline advances normally.
// STRUCTURE
//  - Shared package: AW, NREG, and the stage_rec_t typedef {valid, rd, regwrite, is_load}.
//  - One sub-module, pending_counter_bank: NREG x CW counters with inc/dec ports
//    and pending_mask generation.
//  - The top level holds the 3-stage record shift and the stall logic.
// TESTING
//  1. Reset asserted mid-stream with 3 records in flight -> all outputs 0, pending_mask=0
//     in the same cycle.
//  2. Issue lw x5, then add x6,x5,x1 -> stall_id=1 for exactly 1 cycle.
//     The next cycle shows rd_mem=5, RegWrite_mem=1, RegWrite_ex=0 (bubble).
//  3. Issue addi x7, then 3 ALU ops -> RegWrite_mem/wb track x7 on cycles +2 and +3.
//     stall_id stays 0 throughout.
//  4. mem_stall high for 4 cycles with a load in MEM -> records frozen, stall_id=1,
//     counters unchanged; everything resumes on the first cycle mem_stall=0.
//  5. Three back-to-back writes to x9 -> pending_mask[9]=1, cnt reaches 3 and drains to 0.
//     Same-cycle issue and retire of x9 keeps cnt constant.
//  6. Write to x0, and flush asserted together with id_valid -> no counter change,
//     EX record is a bubble.

Source files
------------

// File: rtl/pipeline_hazard_tracker_pkg.sv
// pipeline_hazard_tracker_pkg: shared sizes and the per-stage record type
package pipeline_hazard_tracker_pkg;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int CW = 2;
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          is_load;
  } stage_rec_t;
endpackage

// File: rtl/pipeline_hazard_tracker_if.sv
// pipeline_hazard_tracker_if: ID issue request in, stall/forwarding/debug view out
interface pipeline_hazard_tracker_if;
  import pipeline_hazard_tracker_pkg::*;
  logic            id_valid;
  logic [AW-1:0]   id_rd;
  logic            id_regwrite;
  logic            id_is_load;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            flush;
  logic            mem_stall;
  logic            stall_id;
  logic [AW-1:0]   rd_ex;
  logic            RegWrite_ex;
  logic [AW-1:0]   rd_mem;
  logic            RegWrite_mem;
  logic [AW-1:0]   rd_wb;
  logic            RegWrite_wb;
  logic [NREG-1:0] pending_mask;
  modport master (
    output id_valid, id_rd, id_regwrite, id_is_load, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           flush, mem_stall,
    input  stall_id, rd_ex, RegWrite_ex, rd_mem, RegWrite_mem, rd_wb, RegWrite_wb, pending_mask
  );
  modport slave (
    input  id_valid, id_rd, id_regwrite, id_is_load, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           flush, mem_stall,
    output stall_id, rd_ex, RegWrite_ex, rd_mem, RegWrite_mem, rd_wb, RegWrite_wb, pending_mask
  );
endinterface

// File: rtl/pipeline_hazard_tracker_pending_counter_bank.sv
// pending_counter_bank: per-register in-flight write counters and their nonzero mask
module pending_counter_bank
  import pipeline_hazard_tracker_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic [AW-1:0]   inc_idx,
  input  logic            dec,
  input  logic [AW-1:0]   dec_idx,
  output logic [NREG-1:0] pending_mask
);
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  always_comb begin
    cnt_d = cnt_q;
    pending_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r] + CW'(inc && inc_idx == AW'(r)) - CW'(dec && dec_idx == AW'(r));
      pending_mask[r] = |cnt_q[r];
    end
    cnt_d[0] = '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  // a simultaneous retire of the same register cancels the wrap/underflow
  assert property (@(posedge clk) disable iff (reset)
    !(inc && !(dec && dec_idx == inc_idx) && cnt_q[inc_idx] == '1));
  assert property (@(posedge clk) disable iff (reset)
    !(dec && !(inc && inc_idx == dec_idx) && cnt_q[dec_idx] == '0));
endmodule

// File: rtl/pipeline_hazard_tracker.sv
// pipeline_hazard_tracker: EX/MEM/WB destination records, load-use and memory stall,
// pending-write tracking for the forwarding unit
module pipeline_hazard_tracker
  import pipeline_hazard_tracker_pkg::*;
(
  input logic clk,
  input logic reset,
  pipeline_hazard_tracker_if.slave bus
);
  stage_rec_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
  logic advance, lu1, lu2, stall, accept, inc, dec;
  logic unused;
  always_comb begin
    advance = !bus.mem_stall;
    id_rec = '{valid: 1'b1, rd: bus.id_rd, regwrite: bus.id_regwrite, is_load: bus.id_is_load};
    lu1 = bus.id_use_rs1 && bus.id_rs1 != '0 && ex_q.valid && ex_q.regwrite && ex_q.is_load
          && ex_q.rd == bus.id_rs1;
    lu2 = bus.id_use_rs2 && bus.id_rs2 != '0 && ex_q.valid && ex_q.regwrite && ex_q.is_load
          && ex_q.rd == bus.id_rs2;
    stall = bus.mem_stall || lu1 || lu2;
    accept = bus.id_valid && !stall && !bus.flush;
    ex_d = advance ? (accept ? id_rec : '0) : ex_q;
    mem_d = advance ? ex_q : mem_q;
    wb_d = advance ? mem_q : wb_q;
    inc = accept && bus.id_regwrite && bus.id_rd != '0;
    dec = advance && wb_q.valid && wb_q.regwrite && wb_q.rd != '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
    end
  assign unused = wb_q.is_load;
  assign bus.stall_id = stall;
  assign bus.rd_ex = ex_q.rd;
  assign bus.RegWrite_ex = ex_q.valid && ex_q.regwrite;
  assign bus.rd_mem = mem_q.rd;
  assign bus.RegWrite_mem = mem_q.valid && mem_q.regwrite;
  assign bus.rd_wb = wb_q.rd;
  assign bus.RegWrite_wb = wb_q.valid && wb_q.regwrite;
  pending_counter_bank u_bank (
    .clk(clk),
    .reset(reset),
    .inc(inc),
    .inc_idx(bus.id_rd),
    .dec(dec),
    .dec_idx(wb_q.rd),
    .pending_mask(bus.pending_mask)
  );
endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// tb_pipeline_hazard_tracker: directed vectors; inputs change and outputs are checked at negedge
module tb_pipeline_hazard_tracker;
  logic clk = 0;
  logic reset = 1;
  int n_chk = 0;
  int n_err = 0;
  pipeline_hazard_tracker_if b ();
  pipeline_hazard_tracker dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic fl, input logic ms);
    @(negedge clk);
    b.id_valid = v; b.id_rd = rd; b.id_regwrite = rw; b.id_is_load = ld;
    b.id_rs1 = rs1; b.id_rs2 = rs2; b.id_use_rs1 = u1; b.id_use_rs2 = u2;
    b.flush = fl; b.mem_stall = ms;
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1, rd, 1, 0, rs1, rs2, 1, 1, 0, 0);
  endtask
  initial begin
    idle(2);
    chk("rst_stall", b.stall_id, 0);
    chk("rst_regwrite", {b.RegWrite_ex, b.RegWrite_mem, b.RegWrite_wb}, 0);
    chk("rst_mask", b.pending_mask, 0);
    @(negedge clk) reset = 0;
    // 1: reset with three records in flight
    alu(20, 1, 2); alu(21, 1, 2); alu(22, 1, 2);
    idle(1);
    chk("t1_inflight_rw", {b.RegWrite_ex, b.RegWrite_mem, b.RegWrite_wb}, 3'b111);
    chk("t1_inflight_mask", b.pending_mask, 32'h0070_0000);
    chk("t1_inflight_rd", {b.rd_ex, b.rd_mem, b.rd_wb}, {5'd22, 5'd21, 5'd20});
    #2 reset = 1;
    #1;
    chk("t1_rst_rw", {b.RegWrite_ex, b.RegWrite_mem, b.RegWrite_wb}, 0);
    chk("t1_rst_rd", {b.rd_ex, b.rd_mem, b.rd_wb}, 0);
    chk("t1_rst_mask", b.pending_mask, 0);
    chk("t1_rst_stall", b.stall_id, 0);
    @(negedge clk) reset = 0;
    // 2: lw x5 ; add x6,x5,x1
    drive(1, 5, 1, 1, 2, 0, 1, 0, 0, 0);
    chk("t2_lw_stall", b.stall_id, 0);
    alu(6, 5, 1);
    chk("t2_lu_stall", b.stall_id, 1);
    chk("t2_ex_lw", {b.RegWrite_ex, b.rd_ex}, {1'b1, 5'd5});
    alu(6, 5, 1);
    chk("t2_stall_clear", b.stall_id, 0);
    chk("t2_mem_lw", {b.RegWrite_mem, b.rd_mem}, {1'b1, 5'd5});
    chk("t2_ex_bubble", b.RegWrite_ex, 0);
    idle(1);
    chk("t2_ex_add", {b.RegWrite_ex, b.rd_ex}, {1'b1, 5'd6});
    chk("t2_wb_lw", {b.RegWrite_wb, b.rd_wb}, {1'b1, 5'd5});
    chk("t2_mask", b.pending_mask, 32'h0000_0060);
    idle(3);
    chk("t2_drained", b.pending_mask, 0);
    // 3: addi x7 then three ALU ops reading x7
    alu(7, 1, 0);
    chk("t3_s0", b.stall_id, 0);
    alu(10, 7, 7);
    chk("t3_s1", b.stall_id, 0);
    chk("t3_ex", {b.RegWrite_ex, b.rd_ex}, {1'b1, 5'd7});
    alu(11, 7, 10);
    chk("t3_s2", b.stall_id, 0);
    chk("t3_mem", {b.RegWrite_mem, b.rd_mem}, {1'b1, 5'd7});
    alu(12, 10, 7);
    chk("t3_s3", b.stall_id, 0);
    chk("t3_wb", {b.RegWrite_wb, b.rd_wb}, {1'b1, 5'd7});
    idle(4);
    chk("t3_drained", b.pending_mask, 0);
    // 4: mem_stall for 4 cycles with lw x8 in MEM
    drive(1, 8, 1, 1, 2, 0, 1, 0, 0, 0);
    alu(11, 1, 2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 12, 1, 0, 1, 2, 1, 1, 0, 1);
      chk("t4_stall", b.stall_id, 1);
      chk("t4_frozen", {b.RegWrite_ex, b.rd_ex, b.RegWrite_mem, b.rd_mem, b.RegWrite_wb},
          {1'b1, 5'd11, 1'b1, 5'd8, 1'b0});
      chk("t4_mask", b.pending_mask, 32'h0000_0900);
    end
    alu(12, 1, 2);
    chk("t4_resume_stall", b.stall_id, 0);
    chk("t4_resume_hold", {b.rd_ex, b.rd_mem}, {5'd11, 5'd8});
    idle(1);
    chk("t4_advanced", {b.rd_ex, b.rd_mem, b.rd_wb}, {5'd12, 5'd11, 5'd8});
    chk("t4_adv_mask", b.pending_mask, 32'h0000_1900);
    idle(3);
    chk("t4_drained", b.pending_mask, 0);
    // 5: back-to-back writes to x9, fourth issue coincides with first retire
    alu(9, 1, 2); alu(9, 1, 2); alu(9, 1, 2);
    chk("t5_cnt2", dut.u_bank.cnt_q[9], 2);
    alu(9, 1, 2);
    chk("t5_cnt3", dut.u_bank.cnt_q[9], 3);
    chk("t5_mask", b.pending_mask, 32'h0000_0200);
    idle(1);
    chk("t5_same_cycle", dut.u_bank.cnt_q[9], 3);
    idle(1);
    chk("t5_cnt_d2", dut.u_bank.cnt_q[9], 2);
    idle(1);
    chk("t5_cnt_d1", dut.u_bank.cnt_q[9], 1);
    chk("t5_mask_d1", b.pending_mask, 32'h0000_0200);
    idle(1);
    chk("t5_cnt_d0", dut.u_bank.cnt_q[9], 0);
    chk("t5_mask_d0", b.pending_mask, 0);
    // 6: write to x0, flush with id_valid, flush with load-use
    alu(0, 1, 2);
    drive(1, 13, 1, 0, 1, 2, 1, 1, 1, 0);
    chk("t6_x0_ex", {b.RegWrite_ex, b.rd_ex}, {1'b1, 5'd0});
    chk("t6_x0_mask", b.pending_mask, 0);
    drive(1, 14, 1, 1, 1, 0, 1, 0, 0, 0);
    chk("t6_flush_bubble", b.RegWrite_ex, 0);
    chk("t6_flush_mask", b.pending_mask, 0);
    drive(1, 15, 1, 0, 3, 14, 1, 1, 1, 0);
    chk("t6_flush_lu_stall", b.stall_id, 1);
    idle(1);
    chk("t6_flush_lu_ex", b.RegWrite_ex, 0);
    chk("t6_flush_lu_mem", {b.RegWrite_mem, b.rd_mem}, {1'b1, 5'd14});
    chk("t6_flush_lu_mask", b.pending_mask, 32'h0000_4000);
    idle(3);
    chk("t6_drained", b.pending_mask, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
